text_buffer: RTL and testbench
==============================

TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 Parameter COLS, default 16, characters per row; SHALL be at least 2.
REQ-002 Parameter ROWS, default 4, number of rows; SHALL be at least 2.
REQ-003 Parameter FILL_CHAR, default 8'h20, byte written by clear and scroll.
REQ-004 Derived constants: N = COLS*ROWS; AW = clog2(N).
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  direct write strobe.
REQ-008 wr_addr  in  AW  direct write cell index.
REQ-009 wr_data  in  8  direct write byte.
REQ-010 put_en  in  1  teletype write strobe at cursor.
REQ-011 put_data  in  8  teletype byte.
REQ-012 clr  in  1  clear-screen request.
REQ-013 busy  out  1  high while clear or scroll is running.
REQ-014 rd_addr  in  AW  display read index from the text renderer.
REQ-015 rd_data  out  8  registered display read byte.
REQ-016 cursor  out  AW  current teletype cell index.

Function
REQ-017 Storage: N bytes; cell index = row*COLS + col.
REQ-018 Read: every cycle, rd_data <= mem[rd_addr]; latency 1 clk; reads continue during busy and show in-progress contents.
REQ-019 Read with rd_addr >= N: rd_data <= FILL_CHAR.
REQ-020 FSM states: IDLE, CLEAR, SCROLL.
REQ-021 Commands are accepted only in IDLE with busy low; while busy, wr_en, put_en and clr are ignored and dropped.
REQ-022 Priority among commands asserted in the same IDLE cycle: clr > put_en > wr_en; lower-priority commands are dropped.
REQ-023 Direct write: mem[wr_addr] <= wr_data; write with wr_addr >= N is ignored; cursor is unchanged.
REQ-024 Put of 8'h0D: cursor <= start of the current row; no memory write.
REQ-025 Put of 8'h0A, not on the last row: cursor <= start of the next row.
REQ-026 Put of 8'h0A on the last row: enter SCROLL; cursor <= (ROWS-1)*COLS.
REQ-027 Put of any other byte: mem[cursor] <= put_data; if cursor < N-1, cursor <= cursor+1.
REQ-028 Put of any other byte with cursor = N-1: the byte is written first, then SCROLL is entered; cursor <= (ROWS-1)*COLS.
REQ-029 clr accepted: enter CLEAR; cursor <= 0.
REQ-030 CLEAR: writes FILL_CHAR to cells 0..N-1, one cell per clk, ascending; N cycles; then IDLE.
REQ-031 SCROLL: copies mem[i] <= mem[i+COLS] for i = 0..N-COLS-1, one per clk, ascending.
REQ-032 SCROLL, after the copy: writes FILL_CHAR to cells N-COLS..N-1; N cycles total; then IDLE.
REQ-033 busy goes high on the edge that accepts the triggering command and stays high exactly N cycles; the first command is accepted on the edge at which busy returns low.
REQ-034 cursor SHALL never exceed N-1.
REQ-035 Internal sweep counter wraps from N-1 to 0 only on return to IDLE.

Reset
REQ-036 rst high at a clock edge: state <= CLEAR, sweep counter <= 0, cursor <= 0, rd_data <= 8'h00, busy <= 1.
REQ-037 rst aborts any CLEAR or SCROLL in progress and restarts the full N-cycle clear.
REQ-038 Commands asserted together with rst are dropped.
REQ-039 After rst deasserts: busy stays high N cycles, then all cells = FILL_CHAR.

Verification (COLS=16, ROWS=4, N=64)
REQ-040 rst for 1 clk -> busy high 64 cycles; then every rd_addr 0..63 returns 8'h20; cursor = 0.
REQ-041 wr_en with addr 5, data 8'h41; next cycle rd_addr=5 -> rd_data = 8'h41 one clk later; wr_addr 63 works; cursor unchanged.
REQ-042 Put 'H','i',8'h0A,'X' -> mem[0]=8'h48, mem[1]=8'h69, mem[16]=8'h58, cursor = 17; then put 8'h0D -> cursor = 16.
REQ-043 From clear, put 64 bytes 8'h40+(i%32) -> on 64th put, busy high 64 cycles; then mem[0..47] = former mem[16..63], mem[48..63] = 8'h20, cursor = 48.
REQ-044 clr and put_en same cycle -> put dropped, all cells 8'h20 after 64 cycles, cursor = 0; any wr_en or put_en during busy leaves memory unchanged.
REQ-045 rst pulsed 10 cycles into a scroll -> busy held 64 cycles from release; all cells 8'h20; cursor = 0.

Source files
------------

// File: rtl/text_buffer_if.sv
// text_buffer_if: command, display-read and status signals of the text buffer.
interface text_buffer_if #(parameter int AW = 6);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          put_en;
  logic [7:0]    put_data;
  logic          clr;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] cursor;
  modport master (
    output wr_en, wr_addr, wr_data, put_en, put_data, clr, rd_addr,
    input  busy, rd_data, cursor
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, put_en, put_data, clr, rd_addr,
    output busy, rd_data, cursor
  );
endinterface

// File: rtl/text_buffer.sv
// text_buffer: character screen memory with direct writes, teletype cursor,
// clear and one-row scroll sweeps, and a registered display read port.
module text_buffer #(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 4,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input logic          clk,
  input logic          rst,
  text_buffer_if.slave bus
);
  localparam int N = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam logic [AW:0]   N_W       = (AW+1)'(N);
  localparam logic [AW-1:0] LAST_CELL = AW'(N - 1);
  localparam logic [AW-1:0] LAST_ROW  = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] COLS_W    = AW'(COLS);
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, cursor_q, cursor_d, row_start, src, waddr;
  logic [7:0]    mem_q [N];
  logic [7:0]    rd_data_q, wdata;
  logic          we, last;
  assign row_start   = AW'((int'(cursor_q) / COLS) * COLS);
  assign src         = cnt_q + COLS_W;
  assign last        = cnt_q == LAST_CELL;
  assign bus.busy    = state_q != IDLE;
  assign bus.rd_data = rd_data_q;
  assign bus.cursor  = cursor_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    we       = 1'b0;
    waddr    = cnt_q;
    wdata    = FILL_CHAR;
    if (state_q == IDLE) begin
      if (bus.clr) begin
        state_d  = CLEAR;
        cursor_d = '0;
      end else if (bus.put_en) begin
        if (bus.put_data == 8'h0D) begin
          cursor_d = row_start;
        end else if (bus.put_data == 8'h0A) begin
          state_d  = cursor_q >= LAST_ROW ? SCROLL : IDLE;
          cursor_d = cursor_q >= LAST_ROW ? LAST_ROW : row_start + COLS_W;
        end else begin
          we       = 1'b1;
          waddr    = cursor_q;
          wdata    = bus.put_data;
          state_d  = cursor_q == LAST_CELL ? SCROLL : IDLE;
          cursor_d = cursor_q == LAST_CELL ? LAST_ROW : cursor_q + 1'b1;
        end
      end else if (bus.wr_en && {1'b0, bus.wr_addr} < N_W) begin
        we    = 1'b1;
        waddr = bus.wr_addr;
        wdata = bus.wr_data;
      end
    end else begin
      // one cell per cycle; scroll pulls from one row down until the last row
      we      = 1'b1;
      wdata   = (state_q == SCROLL && cnt_q < LAST_ROW) ? mem_q[src] : FILL_CHAR;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      cursor_q  <= '0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cursor_q  <= cursor_d;
      rd_data_q <= ({1'b0, bus.rd_addr} < N_W) ? mem_q[bus.rd_addr] : FILL_CHAR;
    end
  end
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= wdata;
  end
endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: directed stimulus for text_buffer, checked every cycle against
// a screen-image model plus literal expectations for the key scenarios.
module tb_text_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  text_buffer_if #(.AW(6)) bus();
  text_buffer #(.COLS(16), .ROWS(4), .FILL_CHAR(8'h20)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Model: the screen image, plus a target image that a sweep reveals one cell per cycle.
  logic [7:0] m_mem [64];
  bit         m_kn [64];
  logic [7:0] m_final [64];
  int         m_left = 0, m_done = 0, m_cursor = 0;
  logic [7:0] m_rd = 8'h00;
  bit         m_rd_kn = 1'b0, m_valid = 1'b0;
  task automatic start_clear();
    for (int i = 0; i < 64; i++) m_final[i] = 8'h20;
    m_left = 64;
    m_done = 0;
  endtask
  task automatic start_scroll();
    for (int i = 0; i < 64; i++) begin
      if (i < 48) m_final[i] = m_mem[i + 16];
      else m_final[i] = 8'h20;
    end
    m_left = 64;
    m_done = 0;
  endtask
  initial for (int i = 0; i < 64; i++) m_kn[i] = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_rd = 8'h00;
      m_rd_kn = 1'b1;
      m_valid = 1'b1;
      m_cursor = 0;
      start_clear();
    end else begin
      m_rd = m_mem[int'(bus.rd_addr)];
      m_rd_kn = m_kn[int'(bus.rd_addr)];
      if (m_left > 0) begin
        m_mem[m_done] = m_final[m_done];
        m_kn[m_done] = 1'b1;
        m_done++;
        m_left--;
      end else if (bus.clr) begin
        m_cursor = 0;
        start_clear();
      end else if (bus.put_en) begin
        if (bus.put_data == 8'h0D) m_cursor = m_cursor - m_cursor % 16;
        else if (bus.put_data == 8'h0A) begin
          if (m_cursor >= 48) begin
            start_scroll();
            m_cursor = 48;
          end else m_cursor = (m_cursor / 16 + 1) * 16;
        end else begin
          m_mem[m_cursor] = bus.put_data;
          m_kn[m_cursor] = 1'b1;
          if (m_cursor == 63) begin
            start_scroll();
            m_cursor = 48;
          end else m_cursor++;
        end
      end else if (bus.wr_en) begin
        m_mem[int'(bus.wr_addr)] = bus.wr_data;
        m_kn[int'(bus.wr_addr)] = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("cursor", 32'(bus.cursor), 32'(m_cursor));
      if (m_rd_kn) chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    end
  end
  task automatic idle_inputs();
    bus.wr_en = 1'b0;
    bus.put_en = 1'b0;
    bus.clr = 1'b0;
  endtask
  task automatic expect_rd(input int a, input logic [7:0] v, input string nm);
    bus.rd_addr = 6'(a);
    @(negedge clk);
    chk(nm, 32'(bus.rd_data), 32'(v));
  endtask
  task automatic put(input logic [7:0] b);
    bus.put_en = 1'b1;
    bus.put_data = b;
    @(negedge clk);
    bus.put_en = 1'b0;
  endtask
  task automatic wait_idle(input bit junk, output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      bus.wr_en = junk;
      bus.wr_addr = 6'(n);
      bus.wr_data = 8'hEE;
      bus.put_en = junk;
      bus.put_data = 8'h41;
      n++;
      @(negedge clk);
    end
    idle_inputs();
  endtask
  task automatic expect_blank(input string nm);
    for (int i = 0; i < 64; i++) expect_rd(i, 8'h20, nm);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    idle_inputs();
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.put_data = '0;
    bus.rd_addr = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy), 32'd1);
    chk("reset_cursor", 32'(bus.cursor), 32'd0);
    chk("reset_rd", 32'(bus.rd_data), 32'd0);
    wait_idle(1'b0, n);
    chk("reset_busy_len", 32'(n), 32'd64);
    expect_blank("reset_blank");
    bus.wr_en = 1'b1;
    bus.wr_addr = 6'd5;
    bus.wr_data = 8'h41;
    @(negedge clk);
    bus.wr_addr = 6'd63;
    bus.wr_data = 8'h7E;
    @(negedge clk);
    bus.wr_en = 1'b0;
    expect_rd(5, 8'h41, "wr5");
    expect_rd(63, 8'h7E, "wr63");
    chk("wr_cursor", 32'(bus.cursor), 32'd0);
    bus.wr_en = 1'b1;
    bus.wr_addr = 6'd40;
    bus.wr_data = 8'h99;
    put(8'h48);
    bus.wr_en = 1'b0;
    put(8'h69);
    put(8'h0A);
    put(8'h58);
    expect_rd(0, 8'h48, "put_H");
    expect_rd(1, 8'h69, "put_i");
    expect_rd(16, 8'h58, "put_X");
    expect_rd(40, 8'h20, "wr_dropped_by_put");
    chk("cursor17", 32'(bus.cursor), 32'd17);
    put(8'h0D);
    chk("cursor_cr", 32'(bus.cursor), 32'd16);
    bus.clr = 1'b1;
    put(8'h5A);
    bus.clr = 1'b0;
    wait_idle(1'b1, n);
    chk("clr_busy_len", 32'(n), 32'd64);
    expect_blank("clr_blank");
    chk("clr_cursor", 32'(bus.cursor), 32'd0);
    for (int i = 0; i < 64; i++) put(8'h40 + 8'(i % 32));
    chk("wrap_busy", 32'(bus.busy), 32'd1);
    wait_idle(1'b1, n);
    chk("scroll_busy_len", 32'(n), 32'd64);
    for (int i = 0; i < 64; i++)
      expect_rd(i, i < 48 ? 8'h40 + 8'((i + 16) % 32) : 8'h20, "scroll_img");
    chk("scroll_cursor", 32'(bus.cursor), 32'd48);
    put(8'h51);
    expect_rd(48, 8'h51, "put_row3");
    put(8'h0A);
    chk("lf_scroll_cursor", 32'(bus.cursor), 32'd48);
    repeat (9) @(negedge clk);
    chk("lf_scroll_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.put_en = 1'b1;
    bus.put_data = 8'h42;
    @(negedge clk);
    rst = 1'b0;
    bus.put_en = 1'b0;
    wait_idle(1'b0, n);
    chk("abort_busy_len", 32'(n), 32'd64);
    expect_blank("abort_blank");
    chk("abort_cursor", 32'(bus.cursor), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
